// File: rtl/cell_seq_pkg.sv
// Shared types for the cell sequencer: FSM state encoding and host command codes.
package cell_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StParam,
    StIssue,
    StWait,
    StResp
  } cell_seq_state_e;

  localparam logic [1:0] CMD_PARAM  = 2'd0;
  localparam logic [1:0] CMD_RUN    = 2'd1;
  localparam logic [1:0] CMD_CLRERR = 2'd2;
  localparam logic [1:0] CMD_RSVD   = 2'd3;

endpackage

// File: rtl/cell_seq_if.sv
// Host command, cell parameter/data bus and result handshake for the cell sequencer.
// The sequencer takes the slave modport; the host/cell side takes master.
interface cell_seq_if #(
  parameter int unsigned MSB    = 31,
  parameter int unsigned NCELLS = 4
);

  logic              host_valid;
  logic              host_ready;
  logic [1:0]        host_cmd;
  logic [7:0]        host_addr;
  logic [MSB:0]      host_data;
  logic [NCELLS-1:0] param_en;
  logic [MSB:0]      param_out;
  logic              data_en;
  logic [MSB:0]      data_out;
  logic              res_en;
  logic [MSB:0]      res_in;
  logic              result_valid;
  logic              result_ready;
  logic [MSB:0]      result_data;
  logic              addr_err;
  logic              timeout_err;

  modport master (
    output host_valid, host_cmd, host_addr, host_data, res_en, res_in, result_ready,
    input  host_ready, param_en, param_out, data_en, data_out, result_valid, result_data,
    input  addr_err, timeout_err
  );

  modport slave (
    input  host_valid, host_cmd, host_addr, host_data, res_en, res_in, result_ready,
    output host_ready, param_en, param_out, data_en, data_out, result_valid, result_data,
    output addr_err, timeout_err
  );

endinterface

// File: rtl/cell_seq_timer.sv
// Response watchdog down-counter: load with TIMEOUT, decrement until zero.
module cell_seq_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned Width = $clog2(TIMEOUT + 1);

  logic [Width-1:0] count_d, count_q;

  // Next count: load has priority, decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = Width'(TIMEOUT);
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/cell_sequencer.sv
// Host-side initiator for the cell parameter/data bus.
// Optional response watchdog enabled by defining CELL_SEQ_TIMEOUT_EN.
module cell_sequencer
  import cell_seq_pkg::*;
#(
  parameter int unsigned MSB     = 31,
  parameter int unsigned NCELLS  = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic     clk,
  input  logic     rst_n,
  cell_seq_if.slave bus
);

  localparam logic [NCELLS-1:0] OneHot0 = NCELLS'(1);

  if (NCELLS < 1 || NCELLS > 256 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
    $error("cell_sequencer: NCELLS or TIMEOUT out of range");
  end

  cell_seq_state_e   state_q;
  logic [NCELLS-1:0] param_en_q;
  logic [MSB:0]      param_out_q;
  logic              data_en_q;
  logic [MSB:0]      data_out_q;
  logic              result_valid_q;
  logic [MSB:0]      result_data_q;
  logic              addr_err_q;
  logic              addr_ok;

  // Widen so NCELLS = 256 compares correctly against an 8-bit address.
  assign addr_ok = ({1'b0, bus.host_addr} < 9'(NCELLS));

`ifdef CELL_SEQ_TIMEOUT_EN
  logic timeout_err_q;
  logic timer_zero;

  cell_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q == StIssue),
    .dec_i  ((state_q == StWait) && !bus.res_en),
    .zero_o (timer_zero)
  );
`endif

  // Sequencer FSM with registered strobes, result capture and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      param_en_q     <= '0;
      param_out_q    <= '0;
      data_en_q      <= 1'b0;
      data_out_q     <= '0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      addr_err_q     <= 1'b0;
`ifdef CELL_SEQ_TIMEOUT_EN
      timeout_err_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.host_valid) begin
            unique case (bus.host_cmd)
              CMD_PARAM: begin
                if (addr_ok) begin
                  param_out_q <= bus.host_data;
                  param_en_q  <= OneHot0 << bus.host_addr;
                  state_q     <= StParam;
                end else begin
                  addr_err_q  <= 1'b1;
                end
              end
              CMD_RUN: begin
                data_out_q <= bus.host_data;
                data_en_q  <= 1'b1;
                state_q    <= StIssue;
              end
              CMD_CLRERR: begin
                addr_err_q    <= 1'b0;
`ifdef CELL_SEQ_TIMEOUT_EN
                timeout_err_q <= 1'b0;
`endif
              end
              CMD_RSVD: begin
              end
            endcase
          end
        end
        StParam: begin
          param_en_q <= '0;
          state_q    <= StIdle;
        end
        StIssue: begin
          data_en_q <= 1'b0;
          state_q   <= StWait;
        end
        StWait: begin
          // A response on the last watchdog cycle still wins over the abort.
          if (bus.res_en) begin
            result_data_q  <= bus.res_in;
            result_valid_q <= 1'b1;
            state_q        <= StResp;
          end
`ifdef CELL_SEQ_TIMEOUT_EN
          else if (timer_zero) begin
            timeout_err_q <= 1'b1;
            state_q       <= StIdle;
          end
`endif
        end
        StResp: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.host_ready   = (state_q == StIdle);
  assign bus.param_en     = param_en_q;
  assign bus.param_out    = param_out_q;
  assign bus.data_en      = data_en_q;
  assign bus.data_out     = data_out_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_data  = result_data_q;
  assign bus.addr_err     = addr_err_q;
`ifdef CELL_SEQ_TIMEOUT_EN
  assign bus.timeout_err  = timeout_err_q;
`else
  assign bus.timeout_err  = 1'b0;
`endif

endmodule
